// File: rtl/mult_share_pkg.sv
// Shared constants and tag type for the shared-multiplier arbiter.
package mult_share_pkg;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = 3;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/multiplierArray.sv
// Pipelined unsigned multiplier, LAT register stages, no reset on the datapath.
module multiplierArray #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y
);
  localparam int PW = 2 * WIDTH;

  logic [LAT-1:0][PW-1:0] p;

  always_ff @(posedge clk) begin
    p[0] <= PW'(a) * PW'(b);
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end

  assign y = p[LAT-1];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; search starts at rr_ptr, pointer moves past each winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);
  logic [IDW-1:0] rr_ptr;

  always_comb begin
    logic [IDW:0] s;
    s       = '0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      if (en && !gnt_any && req[s[IDW-1:0]]) begin
        gnt[s[IDW-1:0]] = 1'b1;
        gnt_id          = s[IDW-1:0];
        gnt_any         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// One pipelined multiplier shared by NREQ requesters; a {valid,id} tag pipe
// travels beside the datapath so each product returns with its owner's ID.
module mult_share_arbiter #(
  parameter int WIDTH = mult_share_pkg::WIDTH,
  parameter int NREQ  = mult_share_pkg::NREQ,
  parameter int IDW   = mult_share_pkg::IDW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [2*WIDTH-1:0]    res_y,
  output logic                  busy,
  output logic [15:0]           issued_cnt
);
  localparam int LAT = mult_share_pkg::LAT;
  localparam int PW  = 2 * WIDTH;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tagw_t;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [PW-1:0]    mul_y, y_hold;
  logic [IDW-1:0]   id_hold;
  tagw_t [LAT:1]    tag_pipe;

  // Gating with rst_n keeps req_ready low while reset is held.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en & rst_n),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mul_a = mul_a | req_a[i*WIDTH +: WIDTH];
        mul_b = mul_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  multiplierArray #(.WIDTH(WIDTH), .LAT(LAT)) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .y   (mul_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe   <= '0;
      id_hold    <= '0;
      y_hold     <= '0;
      issued_cnt <= '0;
    end else begin
      tag_pipe[1] <= '{valid: gnt_any, id: gnt_id};
      for (int i = 2; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      // Outputs keep the last delivered product while the pipe is empty.
      if (tag_pipe[LAT].valid) begin
        id_hold <= tag_pipe[LAT].id;
        y_hold  <= mul_y;
      end
      if (gnt_any) issued_cnt <= issued_cnt + 16'd1;
    end
  end

  assign res_valid = tag_pipe[LAT].valid;
  assign res_id    = tag_pipe[LAT].valid ? tag_pipe[LAT].id : id_hold;
  assign res_y     = tag_pipe[LAT].valid ? mul_y : y_hold;

  always_comb begin
    busy = gnt_any;
    for (int i = 1; i <= LAT; i++) busy = busy | tag_pipe[i].valid;
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined 8-bit multiplier array (multiplierArray, 3-cycle latency) between NREQ requesters.
- Per-requester valid/ready operand handshake with a round-robin grant: at most one product is issued per cycle.
- A tag/valid pipeline runs alongside the datapath and returns each product with the winning requester's ID.
- Sits between the processing-element request ports and the shared multiplier in the Ch05 RTL datapath.

Parameters:
- WIDTH, 8: operand width; product is 2*WIDTH.
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width, clog2(NREQ).
- LAT, 3: multiplier latency in cycles; fixed to match multiplierArray.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable; low = no new grants, in-flight products drain
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  packed operand B, same packing
- req_ready  out  NREQ  one-hot grant; operand accepted when valid & ready
- res_valid  out  1  product valid this cycle
- res_id  out  IDW  requester that owns res_y
- res_y  out  2*WIDTH  product
- busy  out  1  any product in flight or being granted
- issued_cnt  out  16  number of accepted operations, wraps at 65535

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, tag-valid pipeline cleared, res_valid=0, res_id=0, busy=0, issued_cnt=0, req_ready=0.
- req_ready is combinational from req_valid, rr_ptr and en.
- When en=0, req_ready=0.
- Otherwise exactly one bit is set: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
- If no requester is valid, req_ready=0.
- Mux: the winner's a/b drive the multiplier inputs. With no winner the inputs are zero; their value is don't-care.
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NREQ at the clock edge. With no grant it holds.
- Wrap: a grant to NREQ-1 sets rr_ptr=0.
- Latency: operands accepted in cycle k give res_valid=1, res_id=winner and res_y=a*b in cycle k+3. Full throughput is one product per cycle.
- Tag pipeline: a 3-stage shift of {valid, id}, reset-clearable. The multiplier's internal registers are not reset; res_valid qualifies res_y.
- Results have no back-pressure. Requesters sample res_* while res_id matches their own ID.
- res_id and res_y hold their last value when res_valid=0; only res_valid is guaranteed 0.
- busy = (|req_ready) | any tag-stage valid.
- issued_cnt increments by 1 on every accepted operation.
- Reset mid-operation: in-flight products are dropped. No res_valid appears for them after reset release.
- en falling with products in flight: the in-flight products still emerge at k+3.
- Arithmetic: unsigned; res_y = a*b in full 2*WIDTH bits, with no truncation.

Decomposition:
- Package mult_share_pkg holds:
  - constants WIDTH=8, NREQ=4, IDW=2, LAT=3;
  - a typedef for the tag struct {valid, id}.
- One sub-module, rr_arbiter (NREQ-wide round-robin grant plus pointer), is instantiated alongside multiplierArray.
- The tag pipeline and operand mux are inline.

Test Plan:
- Single request: reset, en=1, req_valid=0001, a0=5, b0=7 for one cycle. Expect req_ready=0001 in cycle 0, then res_valid=1, res_id=0, res_y=35 in cycle 3, and busy low from cycle 4.
- All contend: req_valid=1111 held 4 cycles with a_i=i+2, b_i=10. Expect grants 0,1,2,3 in consecutive cycles and results 20,30,40,50 with ids 0..3 in cycles 3..6.
- Fairness/wrap: after a grant to 2, assert req_valid=1001. Expect the grant to 3, then 0 on the next cycle, then 3 again.
- Extremes: a=255, b=255 gives res_y=65025. a=0, b=200 gives res_y=0 with res_valid=1.
- en low: req_valid=1111 with en=0. Expect req_ready=0 and issued_cnt unchanged; after en rises, grants resume at rr_ptr.
- Reset mid-flight: issue 3 back-to-back ops, then pull rst_n low in cycle 2 for 1 cycle. Expect no res_valid afterwards, issued_cnt=0 and rr_ptr=0.
